spi_master: RTL

- Master end of the single-byte SPI link; drives ss, sclk and mosi, and samples miso.
- Pairs with the existing SPI slave: ss is active-high (high = selected), data is MSB-first, and the slave shifts on sclk high.
- Sits between the system controller (start/tx_data/rx_data handshake on sys_clk) and the SPI pins.
- One full-duplex transfer of DATA_W bits per start pulse.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_clk_div.sv | 39 +++
 rtl/spi_master.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg
// Definitions shared by both ends of the single-byte SPI link:
//   - default transfer width and sclk half-period, so master and slave agree
//   - state encoding of the master sequencer
package spi_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 4;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SCLK_HI = 3'd2,
    ST_SCLK_LO = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  // Counter width able to hold 0..n-1; at least one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div
// Half-period timer for the SPI master. A down-counter is reloaded with
// CLK_DIV-1 whenever restart is high and ticks on terminal count (zero), so
// after a restart the tick lands exactly CLK_DIV cycles later. With no
// restart it reloads itself and keeps ticking every CLK_DIV cycles.
// Ports:
//   sys_clk  in   system clock
//   rst      in   asynchronous active-high reset
//   restart  in   reload the counter on this edge
//   tick     out  high in the last cycle of a CLK_DIV-cycle interval
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// spi_master
// Master end of the single-byte SPI link. One full-duplex transfer of DATA_W
// bits, MSB first, per accepted start. ss is active-high; the slave shifts on
// sclk high, so mosi is launched on sclk falling and miso is captured on the
// edge that raises sclk.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | ss low, waiting for start
//   SETUP    | ss high, first bit on mosi, sclk still low
//   SCLK_HI  | sclk high; entered by sampling miso and counting a bit
//   SCLK_LO  | sclk low; entered by shifting out the next mosi bit
//   HOLD     | ss held after the last bit; exit loads rx_data, pulses done
//
// Every state but IDLE lasts CLK_DIV cycles, so ss is high for
// (2*DATA_W+1)*CLK_DIV cycles per transfer.
// Ports:
//   sys_clk  in   system clock
//   rst      in   asynchronous active-high reset
//   start    in   transfer request, only looked at in IDLE
//   tx_data  in   byte to send, captured when start is accepted
//   rx_data  out  last received byte, updated with done
//   busy     out  transfer in progress (not in the done cycle)
//   done     out  one-cycle completion pulse
//   ss       out  slave select, active-high
//   sclk     out  serial clock, idles low
//   mosi     out  serial data out, MSB first
//   miso     in   serial data in, synchronous to sys_clk
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              ss,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W);

  state_t state, state_nxt;

  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [BCW-1:0]    bit_cnt;
  logic              tick;
  logic              restart;
  logic              accept;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .sys_clk (sys_clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ss        = 1'b0;
    sclk      = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        ss   = 1'b1;
        busy = 1'b1;
        if (tick) state_nxt = ST_SCLK_HI;
      end
      ST_SCLK_HI: begin
        ss   = 1'b1;
        sclk = 1'b1;
        busy = 1'b1;
        // bit_cnt already counts the bit captured on entry to this state
        if (tick) state_nxt = (bit_cnt == BIT_LAST) ? ST_HOLD : ST_SCLK_LO;
      end
      ST_SCLK_LO: begin
        ss   = 1'b1;
        busy = 1'b1;
        if (tick) state_nxt = ST_SCLK_HI;
      end
      ST_HOLD: begin
        ss   = 1'b1;
        busy = 1'b1;
        if (tick) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Any state change restarts the half-period timer.
  assign restart = (state_nxt != state);
  assign accept  = (state == ST_IDLE) && start;

  // mosi is forced low whenever ss is low; in HOLD it keeps the last bit.
  assign mosi = ss & tx_sr[DATA_W-1];

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        tx_sr   <= tx_data;
        bit_cnt <= '0;
      end
      if (restart && (state_nxt == ST_SCLK_HI)) begin
        rx_sr   <= {rx_sr[DATA_W-2:0], miso};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (restart && (state_nxt == ST_SCLK_LO)) begin
        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
      end
      if ((state == ST_HOLD) && tick) begin
        rx_data <= rx_sr;
        done    <= 1'b1;
      end
    end
  end

endmodule
